// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg: shared widths and global-barrier request/response types used by core barrier units.
package VX_gpu_pkg;
  localparam int NB_WIDTH = 3;
  localparam int NC_WIDTH = 2;
  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } gbar_req_t;
  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_t;
endpackage

// File: rtl/gbar_rr_arbiter.sv
// gbar_rr_arbiter: round-robin one-hot grant; priority moves past the winner only on accept.
module gbar_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int IW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  input  logic                accept,
  output logic [NUM_REQS-1:0] grant,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_valid
);
  logic [IW-1:0] ptr;
  // scanning from the farthest offset down leaves the nearest valid requester as the winner
  always_comb begin
    grant_idx = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQS - 1; i >= 0; i--)
      if (valid[(int'(ptr) + i) % NUM_REQS]) begin
        grant_idx = IW'((int'(ptr) + i) % NUM_REQS);
        grant_valid = 1'b1;
      end
    grant = grant_valid ? NUM_REQS'(1) << grant_idx : '0;
  end
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else if (accept) ptr <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + IW'(1);
endmodule

// File: rtl/gbar_sync_unit.sv
// gbar_sync_unit: cluster-wide barrier arrival counter with one-cycle release broadcast.
// Define GBAR_DUP_CHECK_EN to track per-core arrival masks and flag duplicate arrivals on err_dup.
module gbar_sync_unit #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int NB_WIDTH     = NUM_BARRIERS > 1 ? $clog2(NUM_BARRIERS) : 1,
  parameter int NC_WIDTH     = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_core_id,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic                          rsp_valid,
  output logic [NB_WIDTH-1:0]           rsp_id,
  output logic                          err_dup
);
  logic [NUM_CORES-1:0] grant;
  logic [NC_WIDTH-1:0]  grant_idx;
  logic                 grant_valid, acc, done, dup;
  logic [NB_WIDTH-1:0]  sel_id;
  logic [NC_WIDTH-1:0]  sel_size, sel_cid;
  logic [NC_WIDTH-1:0]  cnt [NUM_BARRIERS];
  gbar_rr_arbiter #(.NUM_REQS(NUM_CORES), .IW(NC_WIDTH)) arb (
    .clk(clk), .reset(reset), .valid(req_valid), .accept(acc),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );
  assign req_ready = reset ? '0 : grant;
  assign acc       = grant_valid && !reset;
  assign sel_id    = req_id[int'(grant_idx)*NB_WIDTH +: NB_WIDTH];
  assign sel_size  = req_size_m1[int'(grant_idx)*NC_WIDTH +: NC_WIDTH];
  assign sel_cid   = req_core_id[int'(grant_idx)*NC_WIDTH +: NC_WIDTH];
  assign done      = cnt[sel_id] == sel_size;
`ifdef GBAR_DUP_CHECK_EN
  logic [NUM_CORES-1:0] mask [NUM_BARRIERS];
  logic [NUM_CORES-1:0] bit_sel;
  assign bit_sel = NUM_CORES'(1) << sel_cid;
  assign dup     = |(mask[sel_id] & bit_sel);
  always_ff @(posedge clk)
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) mask[b] <= '0;
      err_dup <= 1'b0;
    end else if (acc) begin
      if (dup) err_dup <= 1'b1;
      else mask[sel_id] <= done ? '0 : mask[sel_id] | bit_sel;
    end
`else
  logic unused_cid;
  assign unused_cid = ^sel_cid;
  assign dup        = 1'b0;
  assign err_dup    = 1'b0;
`endif
  // a duplicate arrival is consumed without touching the count or releasing the barrier
  always_ff @(posedge clk)
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) cnt[b] <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
    end else begin
      rsp_valid <= acc && !dup && done;
      if (acc && !dup) begin
        cnt[sel_id] <= done ? '0 : cnt[sel_id] + NC_WIDTH'(1);
        if (done) rsp_id <= sel_id;
      end
    end
endmodule

// File: doc/gbar_sync_unit.md
# gbar_sync_unit

Global barrier responder shared by all cores of a cluster. Each core's barrier unit issues a request carrying a barrier id, a participant count and its core id when all of its active warps have arrived at a global barrier. This block arbitrates those requests, counts arrivals per barrier id, and broadcasts a one-cycle response with the barrier id once the last participating core arrives. That response releases the stalled warps in every core.

## Interface
- NUM_CORES, default 4: number of requesting cores, at least 1.
- NUM_BARRIERS, default 8: barrier ids tracked; must be a power of 2.
- NB_WIDTH, default clog2(NUM_BARRIERS), min 1: barrier id width.
- NC_WIDTH, default clog2(NUM_CORES), min 1: core id and size width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_CORES  per-core arrival request.
- req_id  in  NUM_CORES*NB_WIDTH  per-core barrier id; core i occupies slice i.
- req_size_m1  in  NUM_CORES*NC_WIDTH  participating cores minus 1.
- req_core_id  in  NUM_CORES*NC_WIDTH  requester's core id.
- req_ready  out  NUM_CORES  per-core accept.
- rsp_valid  out  1  broadcast release pulse.
- rsp_id  out  NB_WIDTH  barrier id being released.
- err_dup  out  1  sticky duplicate-arrival flag.

## Operation
- Round-robin arbiter grants at most one valid core per cycle.
  - A grant sets req_ready[i] combinationally; acceptance is req_valid[i] && req_ready[i].
  - The priority pointer moves to (granted index + 1) mod NUM_CORES after each accept.
  - The pointer holds when nothing is accepted.
  - A core holds valid and payload stable until it is accepted.
- Barrier table has NUM_BARRIERS entries, indexed by id. Each entry holds count[NC_WIDTH] and, with the macro below, mask[NUM_CORES].
- On accept, with e = table[id]:
  - If e.count == req_size_m1, the barrier completes: clear the entry (count=0, mask=0), then register rsp_valid=1 and rsp_id=id.
  - Otherwise e.count = e.count + 1. Arithmetic is NC_WIDTH wide; it never wraps because completion is checked first.
- req_size_m1 = 0 completes on the first arrival.
- Each arrival compares against its own size_m1. Mixed sizes for one id are software error and are not checked.
- Different ids progress independently and can be interleaved freely.
- A barrier id is reusable the cycle after its release.

## Timing
- Reset state: table cleared, pointer=0, rsp_valid=0, rsp_id=0, err_dup=0. req_ready is 0 while reset is high.
- Accept in cycle T gives the table update at the edge ending T, and any response in cycle T+1.
- rsp_valid is high for exactly one cycle. There is no ready on the response, and every core samples it.
- Back-to-back accepts to the same id in T and T+1 must see the T update, either through a register-based table or forwarding.
- Completing accepts in consecutive cycles give consecutive rsp pulses.
- Reset mid-operation discards all partial arrivals, and no response is emitted for them.
- Throughput is 1 accept per cycle. A waiting core's worst-case latency to grant is NUM_CORES-1 cycles.

## Configuration
- GBAR_DUP_CHECK_EN defined:
  - Each entry keeps a core mask.
  - An arrival whose req_core_id bit is already set is accepted but neither counted nor allowed to complete, and it sets err_dup, which stays set until reset.
  - Counted arrivals set their mask bit, and completion clears the mask.
- Undefined: no mask storage, every arrival counts, err_dup tied 0.

## Structure
- Shared package VX_gpu_pkg holds:
  - NB_WIDTH and NC_WIDTH.
  - gbar_req_t {id, size_m1, core_id} and gbar_rsp_t {id}. These match the fields the per-core barrier unit drives.
- Sub-module gbar_rr_arbiter (NUM_REQS param, valid in, grant one-hot plus index out, pointer update on accept).
- Table and response registers live in the top.

## Test plan
- Cores 0–3 each send id=2, size_m1=3, in successive cycles -> counts 1,2,3; after core 3's accept, one rsp_valid pulse with rsp_id=2, then entry 2 is zero.
- All four cores assert valid together, id=5, size_m1=3 -> grants in order 0,1,2,3, one per cycle; rsp_id=5 the cycle after the fourth accept.
- size_m1=0, id=1 from core 2 -> rsp_valid with rsp_id=1 the next cycle.
- Interleave id=0 (size_m1=1) and id=7 (size_m1=1) from cores 0 and 1 -> two independent pulses, rsp_id=0 then rsp_id=7.
- With GBAR_DUP_CHECK_EN, core 1 sends id=3, size_m1=1 twice -> no rsp, err_dup=1; a subsequent core 0 arrival produces rsp_id=3.
- Two of four arrivals for id=4, then reset, then four fresh arrivals -> exactly one rsp after the fourth post-reset accept.
